// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch front end for the single-cycle CPU core. It owns the
// program counter and issues word fetches to instruction memory over a
// variable-latency req/ack handshake. Fetched words go into a 2-entry queue,
// and the queue head is presented to the core as {PC, instruction}. A taken
// branch reported by the core redirects fetch and flushes the queue.
//
// Handshakes:
//   imem side : imem_req/imem_addr stay stable from the start of a request
//               until the cycle with imem_ack=1. That cycle transfers
//               imem_rdata. The request may drop only on reset.
//   core side : fetch_valid=1 means PC/instruction hold the queue head. The
//               head is consumed in any cycle with fetch_valid & fetch_ready.
//               branch_taken is only honoured in such a consume cycle.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_req/addr      fetch request and word-aligned byte address
//   imem_ack/rdata     response strobe and fetched word
//   fetch_valid/ready  queue head valid / consumed by core
//   PC, instruction    queue head contents (0 when fetch_valid=0)
//   branch_taken       core's Branch & Zero for the consumed instruction
//   ShiftLeftImm       core's shifted sign-extended branch offset
//   dbg_state_o        FSM state (0 IDLE, 1 REQ, 2 DROP)
//   dbg_count_o        queue occupancy
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    input  logic        branch_taken,
    input  logic [31:0] ShiftLeftImm,
    output logic [1:0]  dbg_state_o,
    output logic [1:0]  dbg_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;   // queue head
    logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;   // queue tail

    logic        pop;
    logic        redirect;
    logic        push;
    logic        wr_slot0;
    logic [31:0] target;

    assign pop      = (count_q != 2'd0) && fetch_ready;
    assign redirect = pop && branch_taken;
    // A redirect in the same cycle as an ack discards that word.
    assign push     = (state_q == ST_REQ) && imem_ack && !redirect;
    // The pushed word lands in slot 0 if the queue is (or becomes) empty.
    assign wr_slot0 = (count_q == 2'd0) || ((count_q == 2'd1) && pop);
    assign target   = (pc0_q + 32'd4 + ShiftLeftImm) & 32'hFFFF_FFFC;

    // ---------------- datapath next-state ----------------
    always_comb begin
        count_d     = count_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        pc0_d       = pc0_q;
        ins0_d      = ins0_q;
        pc1_d       = pc1_q;
        ins1_d      = ins1_q;

        if (redirect) begin
            count_d    = 2'd0;
            fetch_pc_d = target;
            // Outstanding request must keep its address until memory acks.
            if ((state_q == ST_REQ) && !imem_ack) begin
                drop_addr_d = fetch_pc_q;
            end
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (pop) begin
                pc0_d  = pc1_q;
                ins0_d = ins1_q;
            end
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                if (wr_slot0) begin
                    pc0_d  = fetch_pc_q;
                    ins0_d = imem_rdata;
                end else begin
                    pc1_d  = fetch_pc_q;
                    ins1_d = imem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            pc0_q       <= 32'd0;
            ins0_q      <= 32'd0;
            pc1_q       <= 32'd0;
            ins1_q      <= 32'd0;
        end else begin
            count_q     <= count_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            pc0_q       <= pc0_d;
            ins0_q      <= ins0_d;
            pc1_q       <= pc1_d;
            ins1_q      <= ins1_d;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((count_d < 2'd2) || redirect) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    state_d = imem_ack ? ST_REQ : ST_DROP;
                end else if (imem_ack) begin
                    state_d = (count_d < 2'd2) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                // The stale response is ignored; fetch_pc already holds the target.
                if (imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem_req    = (state_q != ST_IDLE);
        imem_addr   = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
        fetch_valid = (count_q != 2'd0);
        PC          = fetch_valid ? pc0_q : 32'd0;
        instruction = fetch_valid ? ins0_q : 32'd0;
        dbg_state_o = state_q;
        dbg_count_o = count_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit. A behavioural instruction memory acks
// after a programmable number of wait cycles. Each phase pushes the expected
// {pc, instr} deliveries into exp_q; a negedge monitor pops and compares on
// every fetch_valid & fetch_ready, checks idle outputs are zero and checks
// that a pending request holds its address.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic        fetch_ready = 1'b0;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        branch_taken = 1'b0;
    logic [31:0] ShiftLeftImm = 32'd0;
    logic [1:0]  dbg_state_o;
    logic [1:0]  dbg_count_o;

    int tests_run = 0;
    int fails     = 0;
    int lat       = 0;
    int wait_cnt;

    logic [63:0] exp_q[$];

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .PC           (PC),
        .instruction  (instruction),
        .branch_taken (branch_taken),
        .ShiftLeftImm (ShiftLeftImm),
        .dbg_state_o  (dbg_state_o),
        .dbg_count_o  (dbg_count_o)
    );

    // ---------------- instruction memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h2009_0003;
            32'h0000_0008: return 32'h0109_5020;
            default:       return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic exp_push(input logic [31:0] a, input logic [31:0] w);
        exp_q.push_back({a, w});
    endtask

    // ---------------- scoreboard monitor ----------------
    logic        pend_prev = 1'b0;
    logic [31:0] addr_prev = 32'd0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            pend_prev = 1'b0;
        end else begin
            if (pend_prev && imem_req) chk("addr_hold", imem_addr, addr_prev);
            pend_prev = imem_req && !imem_ack;
            addr_prev = imem_addr;
            if (fetch_valid && fetch_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL unexpected_pop: got PC=%h instr=%h, required no delivery", PC, instruction);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", PC, e[63:32]);
                    chk("pop_instr", instruction, e[31:0]);
                end
            end else if (!fetch_valid) begin
                chk("idle_pc", PC, 32'd0);
                chk("idle_instr", instruction, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int l, input logic rdy);
        rst_n        = 1'b0;
        lat          = l;
        fetch_ready  = rdy;
        branch_taken = 1'b0;
        ShiftLeftImm = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_count", 32'(dbg_count_o), 32'd0);
        chk("rst_state", 32'(dbg_state_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        fetch_ready = 1'b0;
    endtask

    // Wait (bounded) for the head to show a given PC, then report a taken branch.
    task automatic branch_at(input logic [31:0] at_pc, input logic [31:0] imm, output logic found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fetch_valid && PC == at_pc) begin
                found = 1'b1;
                break;
            end
        end
        chk("branch_head_seen", 32'(found), 32'd1);
        if (found) begin
            branch_taken = 1'b1;
            ShiftLeftImm = imm;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic found;
        int   nvalid;
        int   n;

        // Reset and sequential fetch, ack tied high.
        exp_push(32'h0, 32'h2008_0005);
        exp_push(32'h4, 32'h2009_0003);
        exp_push(32'h8, 32'h0109_5020);
        exp_push(32'hC, mem_word(32'hC));
        do_reset(0, 1'b1);
        @(negedge clk);
        chk("start_req", 32'(imem_req), 32'd1);
        chk("start_valid", 32'(fetch_valid), 32'd0);
        @(negedge clk);
        chk("first_valid", 32'(fetch_valid), 32'd1);
        chk("first_pc", PC, 32'h0);
        @(negedge clk);
        chk("second_pc", PC, 32'h4);
        @(negedge clk);
        chk("third_pc", PC, 32'h8);
        wait_drain(50);

        // Wait states: ack 3 cycles after each request.
        exp_push(32'h0, mem_word(32'h0));
        exp_push(32'h4, mem_word(32'h4));
        exp_push(32'h8, mem_word(32'h8));
        exp_push(32'hC, mem_word(32'hC));
        do_reset(3, 1'b1);
        nvalid = 0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (fetch_valid) nvalid++;
            if (i == 5) chk("ws_first_valid", 32'(fetch_valid), 32'd1);
        end
        chk("ws_valid_pulses", 32'(nvalid), 32'd4);
        wait_drain(50);

        // Backpressure: queue fills with 0,4 and requests stop.
        exp_push(32'h0, mem_word(32'h0));
        exp_push(32'h4, mem_word(32'h4));
        exp_push(32'h8, mem_word(32'h8));
        exp_push(32'hC, mem_word(32'hC));
        do_reset(0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                chk("full_count", 32'(dbg_count_o), 32'd2);
                chk("full_req", 32'(imem_req), 32'd0);
            end
        end
        chk("full_head_pc", PC, 32'h0);
        @(posedge clk);
        #1;
        fetch_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("rearm_req", 32'(imem_req), 32'd1);
        wait_drain(50);

        // Taken branch at PC=8, offset 0x10 -> target 0x1C.
        exp_push(32'h0, mem_word(32'h0));
        exp_push(32'h4, mem_word(32'h4));
        exp_push(32'h8, mem_word(32'h8));
        exp_push(32'h1C, mem_word(32'h1C));
        exp_push(32'h20, mem_word(32'h20));
        do_reset(0, 1'b1);
        branch_at(32'h8, 32'h10, found);
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        ShiftLeftImm = 32'd0;
        @(negedge clk);
        chk("br_valid_low", 32'(fetch_valid), 32'd0);
        chk("br_req_addr", imem_addr, 32'h1C);
        @(negedge clk);
        chk("br_target_r2", PC, 32'h1C);
        wait_drain(50);

        // Redirect while a request to 0x10 is pending, 2-cycle ack.
        exp_push(32'h0, mem_word(32'h0));
        exp_push(32'h4, mem_word(32'h4));
        exp_push(32'h8, mem_word(32'h8));
        exp_push(32'hC, mem_word(32'hC));
        exp_push(32'h30, mem_word(32'h30));
        exp_push(32'h34, mem_word(32'h34));
        do_reset(2, 1'b1);
        branch_at(32'hC, 32'h20, found);
        chk("pend_addr", imem_addr, 32'h10);
        chk("pend_noack", 32'(imem_ack), 32'd0);
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        ShiftLeftImm = 32'd0;
        @(negedge clk);
        chk("drop_valid_low", 32'(fetch_valid), 32'd0);
        chk("drop_state", 32'(dbg_state_o), 32'd2);
        chk("drop_addr", imem_addr, 32'h10);
        n = 0;
        while (!imem_ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("drop_ack_seen", 32'(imem_ack), 32'd1);
        @(negedge clk);
        chk("after_drop_req", 32'(imem_req), 32'd1);
        chk("after_drop_addr", imem_addr, 32'h30);
        wait_drain(60);

        // Negative offset at PC=4 wraps: target 0xFFFF_FFF8, then 0xFFFF_FFFC, 0.
        exp_push(32'h0, mem_word(32'h0));
        exp_push(32'h4, mem_word(32'h4));
        exp_push(32'hFFFF_FFF8, 32'h3F21_FFF8);
        exp_push(32'hFFFF_FFFC, 32'h3F21_FFFC);
        exp_push(32'h0, 32'h2008_0005);
        do_reset(0, 1'b1);
        branch_at(32'h4, 32'hFFFF_FFF0, found);
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        ShiftLeftImm = 32'd0;
        @(negedge clk);
        chk("neg_valid_low", 32'(fetch_valid), 32'd0);
        wait_drain(50);

        // Async reset between edges while a request is pending.
        do_reset(3, 1'b0);
        repeat (6) @(negedge clk);
        chk("pre_arst_req", 32'(imem_req), 32'd1);
        chk("pre_arst_valid", 32'(fetch_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_valid", 32'(fetch_valid), 32'd0);
        chk("arst_pc", PC, 32'd0);
        chk("arst_instr", instruction, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        lat         = 0;
        fetch_ready = 1'b1;
        exp_push(32'h0, mem_word(32'h0));
        exp_push(32'h4, mem_word(32'h4));
        exp_push(32'h8, mem_word(32'h8));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        wait_drain(50);

        repeat (3) @(posedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end that sits directly upstream of the single-cycle `CPU` core and supplies it with `PC` and `instruction`. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake with variable latency. Fetched words are buffered in a 2-entry queue and handed to the core over a valid/ready handshake. Taken branches reported by the core redirect fetch and flush the queue.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch byte address, word-aligned.
- `imem_ack`  in  1  memory has returned `imem_rdata` for the current request.
- `imem_rdata`  in  32  fetched instruction word, sampled only when `imem_req & imem_ack`.
- `fetch_valid`  out  1  queue head holds a valid instruction.
- `fetch_ready`  in  1  core consumes the head this cycle.
- `PC`  out  32  address of the head instruction; 0 when `fetch_valid`=0.
- `instruction`  out  32  head instruction; 0 when `fetch_valid`=0.
- `branch_taken`  in  1  core's Branch & Zero for the instruction consumed this cycle.
- `ShiftLeftImm`  in  32  core's shifted sign-extended offset for that branch.

## Operation
- Datapath:
  - `fetch_pc` register, which drives `imem_addr`.
  - Queue of 2 entries of {pc, instr}, with `count` 0..2.
- FSM states:
  - IDLE: `imem_req`=0.
  - REQ: `imem_req`=1, waiting for ack.
  - DROP: `imem_req`=1 at the stale address; the response will be discarded.
- Pop: occurs when `fetch_valid & fetch_ready`.
- Push: occurs on `imem_req & imem_ack` in state REQ. It writes {`fetch_pc`, `imem_rdata`}, then `fetch_pc` += 4, wrapping modulo 2^32.
- Count update: simultaneous push and pop leaves `count` unchanged and keeps FIFO order.
- Redirect:
  - Condition: `branch_taken & fetch_valid & fetch_ready`. `branch_taken` is ignored otherwise.
  - Target: (head pc + 4 + `ShiftLeftImm`) mod 2^32, with bits [1:0] forced to 0.
  - Effect: the queue is flushed (`count`=0), `fetch_pc` = target, and any ack in the same cycle is discarded.
- Transitions:
  - IDLE→REQ when `count_next` < 2 or a redirect occurs.
  - REQ with ack, no redirect: stay in REQ if `count_next` < 2, else go to IDLE.
  - REQ with ack and redirect: stay in REQ; the next address is the target.
  - REQ without ack, with redirect: go to DROP. `imem_addr` holds the old address until ack, since memory requires a stable request.
  - DROP with ack: discard the data and go to REQ at `fetch_pc` (the target). A second redirect while in DROP only updates `fetch_pc`.
- Reset values:
  - `imem_req`=0; `imem_addr`=`RESET_PC`.
  - `fetch_valid`=0; `PC`=0; `instruction`=0.
  - `count`=0; state IDLE.
  - Reset asserted mid-request abandons the transaction immediately. Memory must tolerate `imem_req` dropping.

## Timing
- Startup: `imem_req` rises in the first cycle after `rst_n` deasserts.
- Fetch latency: ack in cycle N → `fetch_valid`=1 with that word in cycle N+1.
- Request hold: `imem_req` and `imem_addr` stay stable from request until ack.
- Back-to-back fetch: the next address appears in the cycle after ack.
- Throughput: with ack tied high and `fetch_ready` tied high, one instruction per cycle is sustained.
- Queue full: `count`=2 with no pop ⇒ `imem_req`=0 in the next cycle. A pop in a cycle with `count`=2 re-arms the request in the next cycle.
- Redirect timing: `fetch_valid`=0 in cycle R+1 after a redirect in cycle R. The target word is valid no earlier than cycle R+2, assuming an ack in cycle R+1.
- `PC` and `instruction` are registered queue-head outputs, with no combinational path from `imem_rdata` to them.

## Test plan
- Reset and sequential fetch:
  - Stimulus: `RESET_PC`=0, `imem_ack`=1, `fetch_ready`=1; memory words 0x20080005, 0x20090003, 0x01095020 at addresses 0/4/8.
  - Required: `PC`=0,4,8 on consecutive cycles, starting at cycle 2 after reset release, with matching `instruction`.
- Wait states:
  - Stimulus: ack arrives 3 cycles after each request.
  - Required: `imem_addr` held stable; one `fetch_valid` pulse per 4 cycles; `PC` sequence 0,4,8,12.
- Backpressure:
  - Stimulus: `fetch_ready`=0 for 6 cycles.
  - Required: `count` saturates at 2 (PCs 0,4); `imem_req`=0 while full. On release, 0,4,8 are delivered in order with no loss or duplication.
- Taken branch:
  - Stimulus: at head `PC`=8, `branch_taken`=1, `ShiftLeftImm`=32'h10.
  - Required: `fetch_valid`=0 in the next cycle; the next delivered `PC`=0x1C; word 12 is never delivered.
- Redirect during outstanding fetch:
  - Stimulus: a redirect occurs while a request to 0x10 is pending with a 2-cycle ack.
  - Required: the 0x10 data is discarded; the next request is at the target.
  - Also: a negative offset 32'hFFFF_FFF0 at `PC`=0x4 gives target 0xFFFF_FFF8 (wrap-around).
- Async reset mid-request:
  - Stimulus: `rst_n` pulled low between clock edges while `imem_req`=1.
  - Required: `imem_req`=0 and `fetch_valid`=0 immediately, without waiting for a clock edge; fetch restarts at `RESET_PC` after release.
